// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared types and sizing helpers for the dual-source merge stage
package merge_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // Pointer width for a FIFO of the given power-of-two depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// rtl/merge_fifo.sv - small per-source FIFO with registered-state push_ready
module merge_fifo
  import merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Ready depends only on count, so a full FIFO never takes a push while popping.
  assign push_ready = (count != FULL_CNT);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wr_ptr <= '0;
    else if (do_push) wr_ptr <= wr_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rd_ptr <= '0;
    else if (do_pop) rd_ptr <= rd_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dual_source_merge.sv
// rtl/dual_source_merge.sv - round-robin merge of two FIFO-buffered sources into one output register
module dual_source_merge
  import merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_data,
  output logic             d_src,
  input  logic             d_ready
);

  logic [WIDTH-1:0] a_head;
  logic [WIDTH-1:0] b_head;
  logic             a_empty;
  logic             b_empty;
  logic             a_pop;
  logic             b_pop;
  logic             load;
  logic             grant_valid;
  src_t             grant_src;
  src_t             last_q;
  src_t             d_src_q;
  logic             d_valid_q;
  logic [WIDTH-1:0] d_data_q;

  merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .reset_n(reset_n),
    .push_valid(a_valid), .push_ready(a_ready), .push_data(a_data),
    .pop(a_pop), .head(a_head), .empty(a_empty)
  );

  merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .reset_n(reset_n),
    .push_valid(b_valid), .push_ready(b_ready), .push_data(b_data),
    .pop(b_pop), .head(b_head), .empty(b_empty)
  );

  assign load = ~d_valid_q | d_ready;

  // Under contention the source that did not win last time gets the slot.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_A;
    if (!a_empty && !b_empty) begin
      grant_valid = 1'b1;
      grant_src   = (last_q == SRC_A) ? SRC_B : SRC_A;
    end else if (!a_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_A;
    end else if (!b_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_B;
    end
  end

  assign a_pop = load & grant_valid & (grant_src == SRC_A);
  assign b_pop = load & grant_valid & (grant_src == SRC_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  d_valid_q <= 1'b0;
    else if (load) d_valid_q <= grant_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 d_data_q <= '0;
    else if (load && grant_valid) d_data_q <= (grant_src == SRC_A) ? a_head : b_head;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 d_src_q <= SRC_A;
    else if (load && grant_valid) d_src_q <= grant_src;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 last_q <= SRC_B;
    else if (load && grant_valid) last_q <= grant_src;
  end

  assign d_valid = d_valid_q;
  assign d_data  = d_data_q;
  assign d_src   = d_src_q;

endmodule

// File: tb/tb_dual_source_merge.sv
// tb/tb_dual_source_merge.sv - randomized self-checking bench for dual_source_merge
module tb_dual_source_merge;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready;
  logic             d_valid;
  logic [WIDTH-1:0] d_data;
  logic             d_src;
  logic             d_ready = 1'b0;

  dual_source_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .d_valid(d_valid), .d_data(d_data), .d_src(d_src), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each source FIFO is a queue, the output register is a word slot.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_src;
  logic             m_last;
  logic             a_acc, b_acc;
  int               pushed, delivered;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 1'b0;
    m_last  = 1'b1;
  endtask

  // One clock: check readiness, advance the model across the edge, check outputs after it.
  task automatic step();
    logic a_rdy, b_rdy;
    int   g;
    a_rdy = (qa.size() < DEPTH);
    b_rdy = (qb.size() < DEPTH);
    check("a_ready", a_ready, a_rdy);
    check("b_ready", b_ready, b_rdy);
    a_acc = a_valid && a_rdy;
    b_acc = b_valid && b_rdy;
    if (a_valid && a_ready) pushed++;
    if (b_valid && b_ready) pushed++;
    if (d_valid && d_ready) delivered++;
    if (!m_valid || d_ready) begin
      g = -1;
      if (qa.size() > 0 && qb.size() > 0) g = (m_last == 1'b0) ? 1 : 0;
      else if (qa.size() > 0)             g = 0;
      else if (qb.size() > 0)             g = 1;
      if (g == 0) begin
        m_data = qa.pop_front(); m_src = 1'b0; m_valid = 1'b1; m_last = 1'b0;
      end else if (g == 1) begin
        m_data = qb.pop_front(); m_src = 1'b1; m_valid = 1'b1; m_last = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (a_acc) qa.push_back(a_data);
    if (b_acc) qb.push_back(b_data);
    @(posedge clk);
    #1;
    check("d_valid", d_valid, m_valid);
    check("d_data", d_data, m_data);
    check("d_src", d_src, m_src);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_valid = 1'($urandom); b_valid = 1'($urandom); d_ready = 1'($urandom);
    a_data = WIDTH'($urandom); b_data = WIDTH'($urandom);
    #1;
    check("rst_d_valid", d_valid, 0);
    check("rst_d_data", d_data, 0);
    check("rst_d_src", d_src, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b0;
  endtask

  logic [8:0] seen[$];

  initial begin
    pushed = 0;
    delivered = 0;
    model_reset();
    #3;
    do_reset();

    // Single source, one-cycle latency, back-to-back throughput
    d_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h11; step();
    check("ss_lat", d_valid, 0);
    a_data = 8'h22; step();
    check("ss_w0", {d_valid, d_src, d_data}, {1'b1, 1'b0, 8'h11});
    a_data = 8'h33; step();
    check("ss_w1", {d_valid, d_src, d_data}, {1'b1, 1'b0, 8'h22});
    a_valid = 1'b0; step();
    check("ss_w2", {d_valid, d_src, d_data}, {1'b1, 1'b0, 8'h33});
    step();
    check("ss_idle", d_valid, 0);

    // Sustained contention alternates starting with a
    do_reset();
    begin
      int na = 0, nb = 0;
      d_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      seen.delete();
      for (int i = 0; i < 10; i++) begin
        a_data = WIDTH'(8'hA0 + na);
        b_data = WIDTH'(8'hB0 + nb);
        step();
        if (a_acc) na++;
        if (b_acc) nb++;
        if (d_valid) seen.push_back({d_src, d_data});
      end
      a_valid = 1'b0; b_valid = 1'b0;
      check("ct_count_ge6", seen.size() >= 6, 1);
      for (int i = 0; i < 6 && i < seen.size(); i++)
        check("ct_word", seen[i], (i % 2) ? (9'h100 | (9'hB0 + 9'(i / 2))) : (9'hA0 + 9'(i / 2)));
    end

    // Backpressure: FIFO fills, output holds, everything drains in order
    do_reset();
    d_ready = 1'b0; b_valid = 1'b1;
    b_data = 8'h51; step();
    b_data = 8'h52; step();
    b_data = 8'h53; step();
    b_valid = 1'b0;
    check("bp_b_full", b_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {d_valid, d_src, d_data}, {1'b1, 1'b1, 8'h51});
      step();
    end
    d_ready = 1'b1;
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      if (d_valid) seen.push_back({d_src, d_data});
      step();
    end
    check("bp_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      check("bp_order", seen[i], 9'h151 + 9'(i));

    // Asynchronous reset with full FIFOs and a held output word
    do_reset();
    d_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = WIDTH'($urandom); b_data = WIDTH'($urandom);
      step();
    end
    check("mr_a_full", a_ready, 0);
    check("mr_b_full", b_ready, 0);
    check("mr_d_valid", d_valid, 1);
    do_reset();
    d_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'h61; b_data = 8'h71; step();
    a_valid = 1'b0; b_valid = 1'b0; step();
    check("mr_first", {d_valid, d_src, d_data}, {1'b1, 1'b0, 8'h61});
    step();
    check("mr_second", {d_valid, d_src, d_data}, {1'b1, 1'b1, 8'h71});

    // Random soak against the model, then drain and reconcile totals
    do_reset();
    pushed = 0;
    delivered = 0;
    for (int i = 0; i < 10000; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_data = WIDTH'($urandom); b_data = WIDTH'($urandom);
      d_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) step();
    check("soak_drained", d_valid, 0);
    check("soak_totals", delivered, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
